// File: rtl/tsp_tour_checker_if.sv
// Bundle between the tsp solver output side and tsp_tour_checker.
//
// master : solver / bench side. Drives the coordinate arrays, the path and
//          the start request; observes the checker report.
// slave  : tsp_tour_checker side.
//
// Signals
//   xs, ys     N x W   city coordinates (unsigned), stable while busy
//   path       N x 32  tour as city indices, sampled when start is accepted
//   start      run request
//   busy       walk in progress
//   done       one-cycle pulse, report valid from this cycle on
//   tour_len   closed-tour Manhattan length
//   valid      last run was a legal permutation
//   err        last run contained an illegal entry
//   err_index  position in path of the first illegal entry
interface tsp_tour_checker_if #(
  parameter int N  = 64,
  parameter int W  = 32,
  parameter int IW = $clog2(N),
  parameter int LW = 40
);

  logic [N-1:0][W-1:0] xs;
  logic [N-1:0][W-1:0] ys;
  logic [N-1:0][31:0]  path;
  logic                start;
  logic                busy;
  logic                done;
  logic [LW-1:0]       tour_len;
  logic                valid;
  logic                err;
  logic [IW-1:0]       err_index;

  modport master (
    output xs, ys, path, start,
    input  busy, done, tour_len, valid, err, err_index
  );

  modport slave (
    input  xs, ys, path, start,
    output busy, done, tour_len, valid, err, err_index
  );

endinterface

// File: rtl/tsp_tour_checker.sv
// Sequential tour checker for the tsp solver output.
//
// On an accepted start the path array is snapshotted and walked one position
// per cycle for exactly N cycles. Each step checks the entry for range and
// duplication (first offender position is latched) and adds the Manhattan
// distance to the next city (wrapping at the end to close the tour). A single
// registered report is produced per run with a one-cycle done pulse.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts a run in progress
//   bus   tsp_tour_checker_if.slave (xs, ys, path, start in;
//         busy, done, tour_len, valid, err, err_index out)
module tsp_tour_checker #(
  parameter int N  = 64,
  parameter int W  = 32,
  parameter int IW = $clog2(N),
  parameter int LW = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  tsp_tour_checker_if.slave    bus
);

  // Width of the walk position counter; kept separate from IW so that an
  // overridden err_index width does not change the walk itself.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE,
    WALK
  } state_t;

  state_t state_q, state_d;

  // Control strobes from the FSM
  logic load;
  logic step;
  logic last;

  // Run context
  logic [N-1:0][31:0] path_q;
  logic [N-1:0]       seen_q;
  logic [LW-1:0]      acc_q;
  logic [CW-1:0]      i_q;
  logic               run_err_q;
  logic [CW-1:0]      first_q;

  // Report registers
  logic               done_q;
  logic [LW-1:0]      tour_len_q;
  logic               valid_q;
  logic               err_q;
  logic [IW-1:0]      err_index_q;

  // Step datapath
  logic [CW-1:0]      i_nxt;
  logic [31:0]        c;
  logic [31:0]        n;
  logic               c_ok;
  logic               n_ok;
  logic [CW-1:0]      c_idx;
  logic [CW-1:0]      n_idx;
  logic               seen_hit;
  logic               illegal;
  logic               first_now;
  logic               run_err_nxt;
  logic [W-1:0]       xc;
  logic [W-1:0]       xn;
  logic [W-1:0]       yc;
  logic [W-1:0]       yn;
  logic [W-1:0]       dx;
  logic [W-1:0]       dy;
  logic [W:0]         d_sum;
  logic [LW-1:0]      d;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = WALK;
        end
      end
      WALK: begin
        // start is deliberately not looked at here
        step = 1'b1;
        if (i_q == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step datapath: legality of the current entry and distance to the next one
  // ---------------------------------------------------------------------------
  always_comb begin
    i_nxt = (i_q == CW'(N - 1)) ? '0 : i_q + 1'b1;

    c    = path_q[i_q];
    n    = path_q[i_nxt];
    c_ok = (c < 32'(N));
    n_ok = (n < 32'(N));

    // Out-of-range indices are steered to entry 0 so every array read stays in
    // bounds; their contribution is discarded below.
    c_idx = c_ok ? c[CW-1:0] : '0;
    n_idx = n_ok ? n[CW-1:0] : '0;

    seen_hit    = c_ok & seen_q[c_idx];
    illegal     = ~c_ok | seen_hit;
    first_now   = illegal & ~run_err_q;
    run_err_nxt = run_err_q | illegal;

    xc = bus.xs[c_idx];
    xn = bus.xs[n_idx];
    yc = bus.ys[c_idx];
    yn = bus.ys[n_idx];

    dx = (xc >= xn) ? (xc - xn) : (xn - xc);
    dy = (yc >= yn) ? (yc - yn) : (yn - yc);

    d_sum = {1'b0, dx} + {1'b0, dy};
    d     = (c_ok && n_ok) ? LW'(d_sum) : '0;
  end

  // ---------------------------------------------------------------------------
  // Run context and report registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      path_q      <= '0;
      seen_q      <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      run_err_q   <= 1'b0;
      first_q     <= '0;
      done_q      <= 1'b0;
      tour_len_q  <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (load) begin
        path_q    <= bus.path;
        seen_q    <= '0;
        acc_q     <= '0;
        i_q       <= '0;
        run_err_q <= 1'b0;
        first_q   <= '0;
      end

      if (step) begin
        if (c_ok) begin
          seen_q[c_idx] <= 1'b1;
        end
        acc_q     <= acc_q + d;
        run_err_q <= run_err_nxt;
        if (first_now) begin
          first_q <= i_q;
        end
        i_q <= i_nxt;
      end

      // The final step's own distance and legality are folded in directly,
      // since acc_q / run_err_q only catch up on this same edge.
      if (last) begin
        tour_len_q <= acc_q + d;
        err_q      <= run_err_nxt;
        valid_q    <= ~run_err_nxt;
        if (!run_err_nxt) begin
          err_index_q <= '0;
        end else if (first_now) begin
          err_index_q <= IW'(i_q);
        end else begin
          err_index_q <= IW'(first_q);
        end
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q == WALK);
  assign bus.done      = done_q;
  assign bus.tour_len  = tour_len_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.err_index = err_index_q;

endmodule

// File: doc/tsp_tour_checker.md
# tsp_tour_checker

Sequential checker on the output side of the `tsp` solver. On a `start` pulse it snapshots the solver's `path` array and walks it once. It verifies that the path is a permutation of city indices `0..N-1`, and it accumulates the closed-tour Manhattan length over the solver's `xs`/`ys` coordinate arrays. The result is one registered report per run, used for on-chip quality monitoring of solver progress and as a scoreboard source in benches.

## Interface
Parameters:
- `N`, default 64: number of cities, i.e. entries in `xs`, `ys` and `path`.
- `W`, default 32: coordinate width, unsigned.
- `IW`, default `$clog2(N)`: width of `err_index`.
- `LW`, default 40: `tour_len` width; must be at least `W+1+$clog2(N)`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `xs`  in  N×W  city x coordinates; must be stable while `busy`.
- `ys`  in  N×W  city y coordinates; must be stable while `busy`.
- `path`  in  N×32  tour as city indices; sampled only when `start` is accepted.
- `start`  in  1  run request.
- `busy`  out  1  walk in progress.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle onward.
- `tour_len`  out  LW  closed-tour Manhattan length.
- `valid`  out  1  1 when the last run found a legal permutation.
- `err`  out  1  1 when the last run found an illegal entry.
- `err_index`  out  IW  position in `path` of the first illegal entry.

## Operation
- States:
  - IDLE: accepts `start`.
  - WALK: processes one path position per cycle, index `i` from 0 to N-1.
- IDLE with `start`=1: copy `path` into `path_q`, clear the `seen[N]` bitmap, the accumulator `acc`, the run error flag and the first-error index, set `i`=0, and go to WALK.
- In IDLE, `start`=0 does nothing. In WALK, `start` is ignored.
- WALK step `i`: let `c`=`path_q[i]` and `n`=`path_q[(i+1) mod N]`. The step at `i`=N-1 wraps to position 0, which closes the tour.
  - Entry `c` is illegal if `c`≥N (all 32 bits compared) or `seen[c]`=1.
  - The first illegal `i` is latched as the error index; later illegal entries do not overwrite it.
  - If `c`<N, set `seen[c]`.
  - Distance `d` = |xs[c]−xs[n]| + |ys[c]−ys[n]|. Both differences are unsigned magnitudes, and the sum is W+1 bits zero-extended to LW.
  - `d` is forced to 0 if `c`≥N or `n`≥N; no out-of-range array read may occur.
  - `acc` += `d`.
- The walk always runs the full N steps; an error never ends it early.
- On the step `i`=N-1:
  - `tour_len` <= `acc + d`.
  - `err` <= run error flag, including the current step.
  - `valid` <= ~`err`.
  - `err_index` <= latched index, or 0 if there was no error.
  - `done` <= 1.
  - Return to IDLE.
- Result outputs hold their values until the next `done`.
- Duplicate detection alone guarantees that all N indices are covered when there is no error, so no separate missing-index check is needed.

## Timing
- Reset: `busy`=0, `done`=0, `tour_len`=0, `valid`=0, `err`=0, `err_index`=0; state IDLE; `seen` and `acc` cleared.
- Reset during WALK aborts the run: no `done` pulse, and all outputs return to their reset values on the next edge.
- `start` accepted at edge k:
  - `busy`=1 in the cycles after edges k … k+N-1.
  - `done`=1 and `busy`=0 in the cycle after edge k+N.
  - Latency is exactly N cycles from acceptance to `done`, independent of the data.
- `start` high in the same cycle as `done` is accepted, since the state is IDLE. The next `done` follows N cycles later, so the back-to-back period is N+1 cycles.
- `rst` takes priority over `start`.
- `done` is a single-cycle pulse and never stays high for two consecutive cycles.

## Test plan
- Identity path 0..63, `xs[i]`=i, `ys`=0, `start` at edge k → `done` in the cycle after edge k+64, `tour_len`=126, `valid`=1, `err`=0, `err_index`=0.
- Identity path with `path[10]`=3 → `err`=1, `valid`=0, `err_index`=10, and the walk still takes exactly 64 cycles.
- `path[5]`=64 and `path[9]`=64 → `err_index`=5. The steps 4→5 and 5→6 add 0 to `tour_len`, and no X appears on any output.
- `xs` alternating 0 and 2^32−1 along the identity path, `ys`=0 → `tour_len`=274877906880, with no overflow.
- Handshake checks:
  - `start` pulsed again at cycle 20 of a walk → ignored; one `done` only.
  - `start` held high through `done` → second `done` exactly 65 cycles after the first.
- `rst` asserted at cycle 30 of a walk → all outputs 0 on the next cycle and no `done`. A fresh `start` then gives the full correct result after 64 cycles.
